// File: rtl/fir_output_requantizer.sv
// Round-half-up arithmetic right shift with saturation, behind a two-entry AXI4-Stream skid buffer.
// Define REQUANT_SAT_STATS_EN to add the sat_count / sat_sticky saturation statistics ports.
//
// state    | meaning
// ST_EMPTY | main and skid registers both empty
// ST_ONE   | main register holds a beat, skid empty
// ST_FULL  | main and skid both hold beats, upstream stalled
module fir_output_requantizer #(
  parameter int DATA_INPUT  = 32,
  parameter int DATA_OUTPUT = 16,
  parameter int SHIFT       = 7
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset,
  input  logic                   s_axis_valid,
  input  logic [DATA_INPUT-1:0]  s_axis_data,
  output logic                   s_axis_ready,
  output logic                   m_axis_valid,
  output logic [DATA_OUTPUT-1:0] m_axis_data,
  input  logic                   m_axis_ready
`ifdef REQUANT_SAT_STATS_EN
  ,
  output logic [15:0]            sat_count,
  output logic                   sat_sticky
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [DATA_INPUT:0] ROUND =
    (SHIFT > 0) ? ({{DATA_INPUT{1'b0}}, 1'b1} << RND_POS) : '0;
  localparam logic signed [DATA_INPUT:0] Q_MAX =
    {{(DATA_INPUT+2-DATA_OUTPUT){1'b0}}, {(DATA_OUTPUT-1){1'b1}}};
  localparam logic signed [DATA_INPUT:0] Q_MIN =
    {{(DATA_INPUT+2-DATA_OUTPUT){1'b1}}, {(DATA_OUTPUT-1){1'b0}}};
  localparam logic [DATA_OUTPUT-1:0] OUT_MAX = {1'b0, {(DATA_OUTPUT-1){1'b1}}};
  localparam logic [DATA_OUTPUT-1:0] OUT_MIN = {1'b1, {(DATA_OUTPUT-1){1'b0}}};

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_main_valid;
  logic                    r_skid_valid;
  logic [DATA_OUTPUT-1:0]  r_main_data;
  logic [DATA_OUTPUT-1:0]  r_skid_data;

  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_load_main_in;
  logic                    w_load_main_skid;
  logic                    w_load_skid;

  logic signed [DATA_INPUT:0] w_ext;
  logic signed [DATA_INPUT:0] w_r;
  logic signed [DATA_INPUT:0] w_q;
  logic                       w_sat_hi;
  logic                       w_sat_lo;
  logic [DATA_OUTPUT-1:0]     w_q_out;

  // One extra bit keeps the rounding add from wrapping at the positive extreme.
  assign w_ext    = $signed({s_axis_data[DATA_INPUT-1], s_axis_data});
  assign w_r      = w_ext + ROUND;
  assign w_q      = w_r >>> SHIFT;
  assign w_sat_hi = (w_q > Q_MAX);
  assign w_sat_lo = (w_q < Q_MIN);
  assign w_q_out  = w_sat_hi ? OUT_MAX :
                    w_sat_lo ? OUT_MIN : w_q[DATA_OUTPUT-1:0];

  assign s_axis_ready = ~r_skid_valid;
  assign m_axis_valid = r_main_valid;
  assign m_axis_data  = r_main_data;

  assign w_accept = s_axis_valid & ~r_skid_valid;
  assign w_xfer   = r_main_valid & m_axis_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_xfer) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_xfer) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state      <= ST_EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_main_valid <= (w_state_nxt != ST_EMPTY);
      r_skid_valid <= (w_state_nxt == ST_FULL);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_data <= w_q_out;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= w_q_out;
      end
    end
  end

`ifdef REQUANT_SAT_STATS_EN
  logic [15:0] r_sat_count;
  logic        r_sat_sticky;
  logic        w_sat_event;

  assign w_sat_event = w_accept & (w_sat_hi | w_sat_lo);

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_sat_count  <= '0;
      r_sat_sticky <= 1'b0;
    end else if (w_sat_event) begin
      r_sat_sticky <= 1'b1;
      if (r_sat_count != 16'hFFFF) begin
        r_sat_count <= r_sat_count + 16'd1;
      end
    end
  end

  assign sat_count  = r_sat_count;
  assign sat_sticky = r_sat_sticky;
`else
  // Saturation flags feed only the output mux in this build.
`endif

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Directed and randomized bench for fir_output_requantizer against a queue-based arithmetic model.
// Set REQUANT_SAT_STATS_EN to also check the saturation statistics ports.
module tb_fir_output_requantizer;

  localparam int DATA_INPUT  = 32;
  localparam int DATA_OUTPUT = 16;
  localparam int SHIFT       = 7;

  logic                   axi_clk = 1'b0;
  logic                   axi_reset;
  logic                   s_axis_valid;
  logic [DATA_INPUT-1:0]  s_axis_data;
  logic                   s_axis_ready;
  logic                   m_axis_valid;
  logic [DATA_OUTPUT-1:0] m_axis_data;
  logic                   m_axis_ready;
`ifdef REQUANT_SAT_STATS_EN
  logic [15:0]            sat_count;
  logic                   sat_sticky;
`endif

  fir_output_requantizer #(
    .DATA_INPUT (DATA_INPUT),
    .DATA_OUTPUT(DATA_OUTPUT),
    .SHIFT      (SHIFT)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_reset   (axi_reset),
    .s_axis_valid(s_axis_valid),
    .s_axis_data (s_axis_data),
    .s_axis_ready(s_axis_ready),
    .m_axis_valid(m_axis_valid),
    .m_axis_data (m_axis_data),
    .m_axis_ready(m_axis_ready)
`ifdef REQUANT_SAT_STATS_EN
    ,
    .sat_count   (sat_count),
    .sat_sticky  (sat_sticky)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_acc    = 0;
  int     n_sat_model = 0;
  longint exp_q[$];
  logic   was_stalled = 1'b0;
  longint stalled_data = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Exact quotient before clamping: (x + half) / 2^SHIFT rounded toward -inf.
  function automatic longint raw_q(input logic [DATA_INPUT-1:0] d);
    longint x;
    x = longint'($signed(d));
    if (SHIFT > 0) x = x + (longint'(1) <<< (SHIFT - 1));
    return x >>> SHIFT;
  endfunction

  function automatic longint model(input logic [DATA_INPUT-1:0] d);
    longint q;
    longint hi;
    longint lo;
    q  = raw_q(d);
    hi = (longint'(1) <<< (DATA_OUTPUT - 1)) - 1;
    lo = -(longint'(1) <<< (DATA_OUTPUT - 1));
    if (q > hi) return hi;
    if (q < lo) return lo;
    return q;
  endfunction

  function automatic bit is_sat(input logic [DATA_INPUT-1:0] d);
    return model(d) != raw_q(d);
  endfunction

  function automatic longint out_s();
    return longint'($signed(m_axis_data));
  endfunction

  // One clock: drive at negedge, observe handshakes, advance to next negedge.
  task automatic step(input logic v, input logic [DATA_INPUT-1:0] d, input logic mr,
                      output bit acc);
    s_axis_valid = v;
    s_axis_data  = d;
    m_axis_ready = mr;
    #1;
    if (was_stalled) begin
      check("stall_valid", longint'(m_axis_valid), 1);
      check("stall_data", out_s(), stalled_data);
    end
    if (m_axis_valid && mr) begin
      if (exp_q.size() == 0) check("extra_beat", out_s(), -999999);
      else check("out_data", out_s(), exp_q.pop_front());
    end
    acc = v && s_axis_ready;
    if (acc) begin
      exp_q.push_back(model(d));
      n_acc++;
      if (is_sat(d)) n_sat_model++;
    end
    was_stalled  = m_axis_valid && !mr;
    stalled_data = out_s();
    @(posedge axi_clk);
    @(negedge axi_clk);
  endtask

  initial begin
    bit              acc;
    bit              pend;
    logic [DATA_INPUT-1:0] pd;
    logic [31:0]     r;
    int              cyc;

    axi_reset    = 1'b1;
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    m_axis_ready = 1'b0;
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    axi_reset = 1'b0;
    check("rst_m_valid", longint'(m_axis_valid), 0);
    check("rst_m_data", out_s(), 0);
    check("rst_s_ready", longint'(s_axis_ready), 1);

    // Basic rounding, back-to-back.
    step(1'b1, 32'd1600, 1'b1, acc);
    check("t2_valid", longint'(m_axis_valid), 1);
    check("t2_first", out_s(), 13);
    check("t2_s_ready", longint'(s_axis_ready), 1);
    step(1'b1, -32'sd1600, 1'b1, acc);
    check("t2_second", out_s(), -12);
    step(1'b0, '0, 1'b1, acc);
    check("t2_idle", longint'(m_axis_valid), 0);

    // Saturation at both rails.
    step(1'b1, 32'h0040_0000, 1'b1, acc);
    check("t3_max", out_s(), 32767);
    step(1'b1, -32'sd4194432, 1'b1, acc);
    check("t3_min", out_s(), -32768);
    step(1'b0, '0, 1'b1, acc);
`ifdef REQUANT_SAT_STATS_EN
    check("t3_sat_count", longint'(sat_count), 2);
    check("t3_sat_sticky", longint'(sat_sticky), 1);
`endif

    // Backpressure fills the skid register.
    step(1'b1, 32'd128, 1'b0, acc);
    step(1'b1, 32'd256, 1'b0, acc);
    check("t4_s_ready_low", longint'(s_axis_ready), 0);
    check("t4_hold1", out_s(), 1);
    step(1'b1, 32'd384, 1'b0, acc);
    check("t4_not_taken", longint'(acc), 0);
    step(1'b1, 32'd384, 1'b0, acc);
    check("t4_hold2", out_s(), 1);
    step(1'b1, 32'd384, 1'b1, acc);
    check("t4_second", out_s(), 2);
    check("t4_s_ready_up", longint'(s_axis_ready), 1);
    step(1'b1, 32'd384, 1'b1, acc);
    check("t4_third", out_s(), 3);
    step(1'b0, '0, 1'b1, acc);
    check("t4_drained", longint'(exp_q.size()), 0);

    // Random valid/ready with upstream holding offered beats.
    n_acc = 0;
    pend  = 1'b0;
    pd    = '0;
    cyc   = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        r    = $urandom();
        case ($urandom_range(0, 3))
          0:       pd = r;
          1:       pd = 32'h003F_FF80 + 32'($urandom_range(0, 255));
          2:       pd = 32'hFFBF_FF00 + 32'($urandom_range(0, 255));
          default: pd = {{12{r[19]}}, r[19:0]};
        endcase
      end
      step(pend, pend ? pd : '0, ($urandom_range(0, 2) != 0), acc);
      if (acc) pend = 1'b0;
      cyc++;
    end
    check("rand_accepts", longint'(n_acc), 1000);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      step(1'b0, '0, 1'b1, acc);
      cyc++;
    end
    check("rand_drained", longint'(exp_q.size()), 0);
`ifdef REQUANT_SAT_STATS_EN
    check("rand_sat_count", longint'(sat_count), (n_sat_model > 65535) ? 65535 : n_sat_model);
    check("rand_sat_sticky", longint'(sat_sticky), (n_sat_model > 0) ? 1 : 0);
`endif

    // Reset while FULL drops both buffered beats.
    step(1'b1, 32'd640, 1'b0, acc);
    step(1'b1, 32'd768, 1'b0, acc);
    check("t6_full", longint'(s_axis_ready), 0);
    s_axis_valid = 1'b0;
    axi_reset    = 1'b1;
    @(posedge axi_clk);
    @(negedge axi_clk);
    axi_reset = 1'b0;
    exp_q.delete();
    n_sat_model = 0;
    was_stalled = 1'b0;
    check("t6_m_valid", longint'(m_axis_valid), 0);
    check("t6_s_ready", longint'(s_axis_ready), 1);
`ifdef REQUANT_SAT_STATS_EN
    check("t6_sat_count", longint'(sat_count), 0);
    check("t6_sat_sticky", longint'(sat_sticky), 0);
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, acc);
      check("t6_no_emit", longint'(m_axis_valid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
